uart_cfg_negotiator: RTL
========================

Name: uart_cfg_negotiator

Overview:
- Parametrised successor to the UART main controller's auto-configuration logic.
- Runs the master or slave configuration-negotiation protocol over the RX/TX FIFO byte streams.
- Configurable timeout and retry budget; per-packet ACK/NACK; staged configuration committed atomically.
- Sits between the RX/TX FIFOs, the CPU register file (CFR) and the interrupt logic.

Parameters:
- TIMEOUT_CYCLES, 2500000, clk cycles to wait for a reply (50 ms at 50 MHz); must be >= 2.
- MAX_RETRIES, 3, resends allowed per packet before the negotiation fails; 1..15.
- STD_CFG, 6'b11_10_00, standard {data_width[1:0], parity[1:0], stop[1:0]} = 8-bit, parity disabled, 1 stop bit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_mst_i  in  1  pulse: CPU requests negotiation as master.
- std_setup_i  in  1  pulse: force standard configuration.
- cfg_wanted_i  in  6  configuration the master proposes.
- rx_valid_i  in  1  RX FIFO not empty; first-word-fall-through.
- rx_data_i  in  8  RX FIFO head byte.
- rx_read_o  out  1  pop RX FIFO.
- tx_full_i  in  1  TX FIFO full.
- tx_write_o  out  1  push TX FIFO.
- tx_data_o  out  8  byte pushed.
- cfg_o  out  6  active configuration.
- cfg_we_o  out  1  one-cycle strobe: cfg_o updated.
- busy_o  out  1  negotiation in progress.
- cfg_err_o  out  1  one-cycle pulse: negotiation failed or illegal field.
- int_en_i  in  1  configuration-error interrupt enable.
- interrupt_o  out  1  sticky cfg_err_o & int_en_i; cleared by start_mst_i or std_setup_i.

Behaviour:
- Packet encoding:
  - Control bytes: REQ=8'hC0, ACK=8'hC1, NACK=8'hC2, END=8'hC3.
  - Field bytes: {id[1:0], 4'b0, opt[1:0]}; id 00 = data width, 01 = parity, 10 = stop bits.
  - Illegal fields: stop opt 11 (reserved); any field byte with bits[5:2] != 0.
- Reset: state IDLE; cfg_o = STD_CFG; all strobes, busy_o and interrupt_o are 0; retry and timeout counters are 0.
- Transmit handshake: a SEND state holds tx_data_o stable and asserts tx_write_o only when !tx_full_i. The write takes effect that cycle, and the FSM advances on the next edge.
- Receive handshake: in WAIT states, rx_read_o = rx_valid_i, and the byte is consumed the same cycle. In IDLE, only a REQ byte is consumed; any other byte is left in the FIFO for the CPU.
- IDLE priority, highest first: std_setup_i > rx REQ > start_mst_i.
  - std_setup_i -> STD.
  - rx REQ -> S_ACK.
  - start_mst_i -> M_REQ.
- STD: cfg_o <= STD_CFG, cfg_we_o = 1, then IDLE. Latency is 1 cycle from the std_setup_i edge.
- Master sequence:
  - M_REQ -> M_WREQ.
  - M_F0 / M_F1 / M_F2 send the fields in order DW, PAR, STOP; each is followed by M_WF.
  - M_END -> M_WEND -> M_APPLY.
- Master WAIT states (M_WREQ, M_WF, M_WEND):
  - ACK -> next SEND state.
  - NACK or timeout -> retry.
  - Any other byte -> treated as NACK.
- Retry: retry_cnt++, then resend the same packet. When retry_cnt == MAX_RETRIES, the next NACK or timeout -> FAIL. retry_cnt clears on every ACK.
- Timeout counter:
  - Clears on entry to any WAIT state.
  - Increments each cycle while no byte is present.
  - Timeout fires when it reaches TIMEOUT_CYCLES-1.
  - A byte arriving on the same cycle as the timeout wins over the timeout.
- Slave sequence:
  - S_ACK sends ACK -> S_WAIT.
  - S_WAIT, legal field: stage it, reply ACK via S_REPLY.
  - S_WAIT, illegal field or unexpected control byte: reply NACK, pulse cfg_err_o, keep the staged value.
  - S_WAIT, END: reply ACK -> S_APPLY.
  - S_WAIT, timeout -> FAIL.
- Staging: the staging register is preloaded with cfg_o (slave) or cfg_wanted_i (master) on leaving IDLE.
- M_APPLY / S_APPLY: cfg_o <= staged value, cfg_we_o = 1 -> IDLE.
- FAIL: cfg_err_o = 1; cfg_o <= STD_CFG, cfg_we_o = 1 -> IDLE. cfg_o is never partially updated.
- busy_o is 1 in every state except IDLE.
- start_mst_i, std_setup_i and REQ are ignored while busy.
- rst_i mid-negotiation returns to IDLE with STD_CFG; the staged value is discarded.

Optional Feature:
- Macro: UART_CFG_STATS_EN.
- When defined:
  - Adds outputs fail_cnt_o[7:0] and nack_cnt_o[7:0].
  - Saturating counters of FAIL entries and of NACKs sent or received.
  - Cleared by rst_i.
- When undefined: the ports and the counters are absent; all other behaviour is identical.

Test Plan (TIMEOUT_CYCLES=16, MAX_RETRIES=3):
- Master happy path: cfg_wanted_i=6'b01_01_01; slave ACKs each byte after 3 cycles. TX sees C0, 01, 41, 81, C3. cfg_o=6'b010101, cfg_we_o pulses once, busy_o falls.
- Master with no reply: REQ is sent 4 times, 16 cycles apart. Then FAIL: cfg_err_o pulse, cfg_o=6'b111000; with int_en_i=1, interrupt_o stays 1 until std_setup_i.
- Slave path: RX bytes C0, 02, 83 (illegal stop), 80, C3. TX sees C1, C1, C2, C1, C1. cfg_o=6'b101000, with one cfg_err_o pulse.
- TX backpressure: tx_full_i=1 for 10 cycles during M_F1. tx_write_o stays 0 and tx_data_o holds 8'h41; exactly one write occurs after release.
- Simultaneous events in IDLE:
  - start_mst_i with REQ present: slave path taken, first TX byte is C1.
  - std_setup_i with REQ present: STD taken, REQ not consumed.
- Reset during S_WAIT: rst_i for 1 cycle. Next cycle: busy_o=0, cfg_o=STD_CFG, no further TX writes.

Source files
------------

// File: rtl/uart_cfg_negotiator.sv
// UART configuration negotiator: master/slave handshake over the RX/TX FIFO byte streams.
// Optional build macro UART_CFG_STATS_EN adds saturating FAIL / NACK statistics outputs.
module uart_cfg_negotiator #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter logic [5:0]  STD_CFG        = 6'b11_10_00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_mst_i,
    input  logic       std_setup_i,
    input  logic [5:0] cfg_wanted_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_read_o,
    input  logic       tx_full_i,
    output logic       tx_write_o,
    output logic [7:0] tx_data_o,
    output logic [5:0] cfg_o,
    output logic       cfg_we_o,
    output logic       busy_o,
    output logic       cfg_err_o,
`ifdef UART_CFG_STATS_EN
    output logic [7:0] fail_cnt_o,
    output logic [7:0] nack_cnt_o,
`endif
    input  logic       int_en_i,
    output logic       interrupt_o
);

    localparam logic [7:0] C_REQ  = 8'hC0;
    localparam logic [7:0] C_ACK  = 8'hC1;
    localparam logic [7:0] C_NACK = 8'hC2;
    localparam logic [7:0] C_END  = 8'hC3;

    localparam int unsigned     TO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

    // state   | meaning
    // IDLE    | quiescent, watching for std_setup / REQ / start
    // STD     | load standard configuration
    // M_*     | master: send REQ, fields F0..F2, END; W* states await ACK
    // S_*     | slave: ACK the REQ, wait for fields, reply, apply
    // FAIL    | report error and fall back to standard configuration
    typedef enum logic [3:0] {
        IDLE, STD,
        M_REQ, M_WREQ, M_F0, M_F1, M_F2, M_WF, M_END, M_WEND, M_APPLY,
        S_ACK, S_WAIT, S_REPLY, S_APPLY,
        FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      stage_q;
    logic [3:0]      retry_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [1:0]      fld_q;
    logic [7:0]      reply_q;
    logic            reply_end_q;

    logic   is_wait, is_mwait, timeout;
    logic   is_end, fld_legal;
    logic   retry_inc, retry_clr;
    state_t ack_next, resend_next;

    assign is_mwait = (state_q == M_WREQ) || (state_q == M_WF) || (state_q == M_WEND);
    assign is_wait  = is_mwait || (state_q == S_WAIT);
    assign timeout  = is_wait && !rx_valid_i && (to_cnt_q == TO_LAST);
    assign busy_o   = (state_q != IDLE);

    // Control bytes all carry id 11, so id 11 is never a legal field.
    assign is_end    = (rx_data_i == C_END);
    assign fld_legal = (rx_data_i[7:6] != 2'b11) && (rx_data_i[5:2] == 4'b0000) &&
                       !((rx_data_i[7:6] == 2'b10) && (rx_data_i[1:0] == 2'b11));

    always_comb begin
        ack_next    = IDLE;
        resend_next = IDLE;
        case (state_q)
            M_WREQ: begin
                ack_next    = M_F0;
                resend_next = M_REQ;
            end
            M_WF: begin
                case (fld_q)
                    2'd0:    begin ack_next = M_F1;  resend_next = M_F0; end
                    2'd1:    begin ack_next = M_F2;  resend_next = M_F1; end
                    default: begin ack_next = M_END; resend_next = M_F2; end
                endcase
            end
            M_WEND: begin
                ack_next    = M_APPLY;
                resend_next = M_END;
            end
            default: begin
                ack_next    = IDLE;
                resend_next = IDLE;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rx_read_o  = 1'b0;
        tx_write_o = 1'b0;
        tx_data_o  = 8'h00;
        cfg_we_o   = 1'b0;
        cfg_err_o  = 1'b0;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (std_setup_i) begin
                    state_d = STD;
                end else if (rx_valid_i && (rx_data_i == C_REQ)) begin
                    rx_read_o = 1'b1;
                    state_d   = S_ACK;
                end else if (start_mst_i) begin
                    state_d = M_REQ;
                end
            end
            STD: begin
                cfg_we_o = 1'b1;
                state_d  = IDLE;
            end
            M_REQ, M_F0, M_F1, M_F2, M_END, S_ACK, S_REPLY: begin
                case (state_q)
                    M_REQ:   tx_data_o = C_REQ;
                    M_F0:    tx_data_o = {2'b00, 4'b0000, stage_q[5:4]};
                    M_F1:    tx_data_o = {2'b01, 4'b0000, stage_q[3:2]};
                    M_F2:    tx_data_o = {2'b10, 4'b0000, stage_q[1:0]};
                    M_END:   tx_data_o = C_END;
                    S_ACK:   tx_data_o = C_ACK;
                    default: tx_data_o = reply_q;
                endcase
                if (!tx_full_i) begin
                    tx_write_o = 1'b1;
                    case (state_q)
                        M_REQ:   state_d = M_WREQ;
                        M_END:   state_d = M_WEND;
                        S_ACK:   state_d = S_WAIT;
                        S_REPLY: state_d = reply_end_q ? S_APPLY : S_WAIT;
                        default: state_d = M_WF;
                    endcase
                end
            end
            M_WREQ, M_WF, M_WEND: begin
                rx_read_o = rx_valid_i;
                if (rx_valid_i && (rx_data_i == C_ACK)) begin
                    retry_clr = 1'b1;
                    state_d   = ack_next;
                end else if (rx_valid_i || timeout) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = resend_next;
                    end
                end
            end
            S_WAIT: begin
                rx_read_o = rx_valid_i;
                if (rx_valid_i) begin
                    cfg_err_o = !(is_end || fld_legal);
                    state_d   = S_REPLY;
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            M_APPLY, S_APPLY: begin
                cfg_we_o = 1'b1;
                state_d  = IDLE;
            end
            FAIL: begin
                cfg_err_o = 1'b1;
                cfg_we_o  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cfg_o   <= STD_CFG;
        end else begin
            state_q <= state_d;
            case (state_q)
                STD, FAIL:        cfg_o <= STD_CFG;
                M_APPLY, S_APPLY: cfg_o <= stage_q;
                default:          cfg_o <= cfg_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q     <= STD_CFG;
            reply_q     <= C_ACK;
            reply_end_q <= 1'b0;
            fld_q       <= 2'd0;
        end else begin
            if (state_q == IDLE) begin
                if (state_d == S_ACK) begin
                    stage_q <= cfg_o;
                end else if (state_d == M_REQ) begin
                    stage_q <= cfg_wanted_i;
                end
            end
            if ((state_q == S_WAIT) && rx_valid_i) begin
                reply_end_q <= is_end;
                reply_q     <= (is_end || fld_legal) ? C_ACK : C_NACK;
                if (fld_legal) begin
                    case (rx_data_i[7:6])
                        2'b00:   stage_q[5:4] <= rx_data_i[1:0];
                        2'b01:   stage_q[3:2] <= rx_data_i[1:0];
                        default: stage_q[1:0] <= rx_data_i[1:0];
                    endcase
                end
            end
            case (state_q)
                M_F0:    fld_q <= 2'd0;
                M_F1:    fld_q <= 2'd1;
                M_F2:    fld_q <= 2'd2;
                default: fld_q <= fld_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == IDLE) || retry_clr) begin
            retry_q <= 4'd0;
        end else if (retry_inc) begin
            retry_q <= retry_q + 4'd1;
        end
        if (rst_i || !is_wait) begin
            to_cnt_q <= '0;
        end else if (!rx_valid_i && !timeout) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            interrupt_o <= 1'b0;
        end else if (cfg_err_o && int_en_i) begin
            interrupt_o <= 1'b1;
        end else if (start_mst_i || std_setup_i) begin
            interrupt_o <= 1'b0;
        end
    end

`ifdef UART_CFG_STATS_EN
    logic nack_evt;

    assign nack_evt = ((state_q == S_REPLY) && tx_write_o && (reply_q == C_NACK)) ||
                      (is_mwait && rx_valid_i && (rx_data_i == C_NACK));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fail_cnt_o <= 8'd0;
            nack_cnt_o <= 8'd0;
        end else begin
            if ((state_q == FAIL) && (fail_cnt_o != 8'hFF)) begin
                fail_cnt_o <= fail_cnt_o + 8'd1;
            end
            if (nack_evt && (nack_cnt_o != 8'hFF)) begin
                nack_cnt_o <= nack_cnt_o + 8'd1;
            end
        end
    end
`endif

endmodule
